ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Shares the single-port 4x4 vending-machine RAM (clk, addr, data_in, we, data_out) between two requesters, e.g. stock-update logic (port 0) and display/readout logic (port 1).
- Uses round-robin arbitration, latches the winning command and sequences the RAM write or synchronous read.
- Returns read data with a one-cycle done pulse to the winner.
- Sits directly in front of the RAM instance; the RAM is never driven by anything else.

Parameters:
- AW, 2, RAM address width
- DW, 4, RAM data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  port-0 request (level; sampled only in IDLE)
- we0  input  1  port-0 command: 1=write, 0=read
- addr0  input  AW  port-0 address
- wdata0  input  DW  port-0 write data
- req1, we1, addr1, wdata1  input  1/1/AW/DW  port-1 equivalents
- gnt0, gnt1  output  1  one-cycle pulse: command accepted and latched
- done0, done1  output  1  one-cycle pulse: operation complete; for reads, rdata valid
- rdata  output  DW  read data, shared, valid when a done pulse follows a read
- busy  output  1  high whenever state is not IDLE
- ram_we  output  1  to RAM we
- ram_addr  output  AW  to RAM addr
- ram_wdata  output  DW  to RAM data_in
- ram_rdata  input  DW  from RAM data_out; the RAM read is synchronous, so data appears the cycle after the address edge

Behaviour:
- Interface clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, gnt0/1=0, done0/1=0, rdata=0, cmd registers=0, last_gnt=1 (port 0 wins the first tie), ram_we=0, busy=0.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE:
  - If any req is high at the edge, latch the winner's we/addr/wdata into cmd registers.
  - Pulse that port's gnt for the following cycle, update last_gnt and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - With only one req, that port wins.
  - With both reqs, the port not equal to last_gnt wins, so the ports strictly alternate under continuous contention.
- ISSUE:
  - ram_addr=cmd_addr, ram_wdata=cmd_wdata, ram_we=cmd_we. ram_we is decoded from state and is never high outside ISSUE.
  - For a write, the next state is IDLE and the winner's done pulses in that IDLE cycle.
  - For a read, the next state is RDWAIT.
- RDWAIT:
  - ram_rdata is valid in this state.
  - At the edge, rdata<=ram_rdata, the winner's done pulses the next cycle and the state goes to IDLE.
- Latency, counted from the edge that samples req (E1):
  - gnt is high in cycle 1.
  - A write is committed at E2; done in cycle 2.
  - A read has rdata and done in cycle 3.
- Throughput:
  - The done cycle is an IDLE cycle and arbitrates normally, so back-to-back writes run 1 per 2 cycles and reads 1 per 3.
- Requester rules:
  - The command may change once gnt is seen.
  - A req still high in any IDLE cycle is a new request, so single-shot requesters drop req in the gnt cycle.
- Reqs during ISSUE/RDWAIT are ignored, not queued.
- rdata holds its value until the next read completes; it is not cleared by writes.
- ram_addr/ram_wdata hold the last command in IDLE; only ram_we is qualified.
- Reset mid-operation (any state): the next cycle is IDLE with all pulses low and ram_we=0. An in-flight read produces no done; an in-flight write is only committed if ISSUE already passed its edge.
- Address wrap: addresses are AW bits; address 3 is a normal location with no special case.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, RDWAIT=2'd2)
  - default AW/DW constants
  - port index localparams P0=0, P1=1
- One natural sub-module, rr_pick2:
  - Combinational two-way round-robin picker with inputs req0, req1, last_gnt and outputs valid, winner.
  - Unit-testable on its own.

Test Plan:
- Reset, then port-0 write addr=0 data=10 (req0 for one cycle) -> gnt0 in cycle 1, ram_we=1 only in cycle 1, done0 in cycle 2. Port-1 read addr=0 -> done1 in cycle 3 with rdata=10.
- req0 and req1 both held high with writes of 5 to addr1 and 9 to addr2 -> grants in order P0, P1, P0, P1, and gnt pulses spaced 2 cycles apart. Subsequent reads return 5 and 9.
- Write 15 to addr 3 and 7 to addr 0, then read addr 3 -> rdata=15 (no aliasing at the top address); a read of addr 0 -> 7.
- Start a read of addr 0 and assert rst during RDWAIT -> no done pulse, busy=0 and ram_we=0 the next cycle, rdata=0. A new read afterwards completes normally.
- Assert req1 during ISSUE of a port-0 command, then drop it before IDLE -> no gnt1 and no RAM activity for port 1.
- Sustained req0 alone with alternating reads and writes -> done on every 2nd cycle for writes and every 3rd for reads, and busy is never low for more than one cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM access arbiter.
// Holds the FSM state encoding, default RAM geometry and the requester
// port indices used by the picker and the top level.
package ram_arb_pkg;

  localparam int AW_DEF = 2;
  localparam int DW_DEF = 4;

  // Port indices; one bit is enough to name the winner of a 2-way pick.
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req0, req1 : request levels from port 0 / port 1
//   last_gnt   : index of the port that won the previous arbitration
//   valid      : at least one request is present
//   winner     : index of the winning port (meaningful when valid)
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // Lone requester wins outright; on a tie the port that did not win last time goes.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = P1;
    end else begin
      winner = P0;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters. The winning command is latched, issued for one cycle, and for
// reads the data is captured one cycle later (synchronous RAM read).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*         : per-port command (req sampled only in IDLE)
//   gnt0/gnt1                     : one-cycle pulse, command accepted
//   done0/done1                   : one-cycle pulse, operation complete
//   rdata                         : last read result, held until next read
//   busy                          : FSM is not IDLE
//   ram_we/ram_addr/ram_wdata     : RAM command outputs
//   ram_rdata                     : RAM read data (valid one cycle after addr)
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_t        state_r, state_nxt_s;
  logic          pick_valid_s, pick_winner_s;
  logic          last_gnt_r;
  logic          cmd_port_r, cmd_we_r;
  logic [AW-1:0] cmd_addr_r;
  logic [DW-1:0] cmd_wdata_r;
  logic [DW-1:0] rdata_r;
  logic          gnt0_r, gnt1_r, done0_r, done1_r;
  logic          gnt0_nxt_s, gnt1_nxt_s, done0_nxt_s, done1_nxt_s;
  logic          load_cmd_s, load_rdata_s;

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_r),
    .valid    (pick_valid_s),
    .winner   (pick_winner_s)
  );

  // State register and registered handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt0_r  <= gnt0_nxt_s;
      gnt1_r  <= gnt1_nxt_s;
      done0_r <= done0_nxt_s;
      done1_r <= done1_nxt_s;
    end
  end

  // Next-state logic and next values of the grant/done pulses.
  always_comb begin
    state_nxt_s  = state_r;
    gnt0_nxt_s   = 1'b0;
    gnt1_nxt_s   = 1'b0;
    done0_nxt_s  = 1'b0;
    done1_nxt_s  = 1'b0;
    load_cmd_s   = 1'b0;
    load_rdata_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          load_cmd_s  = 1'b1;
          state_nxt_s = ISSUE;
          if (pick_winner_s == P1) begin
            gnt1_nxt_s = 1'b1;
          end else begin
            gnt0_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_we_r) begin
          // The write commits on this edge, so done can follow immediately.
          state_nxt_s = IDLE;
          done0_nxt_s = (cmd_port_r == P0);
          done1_nxt_s = (cmd_port_r == P1);
        end else begin
          state_nxt_s = RDWAIT;
        end
      end
      RDWAIT: begin
        state_nxt_s  = IDLE;
        load_rdata_s = 1'b1;
        done0_nxt_s  = (cmd_port_r == P0);
        done1_nxt_s  = (cmd_port_r == P1);
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Command latch, round-robin history and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_port_r  <= P0;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_wdata_r <= '0;
      last_gnt_r  <= P1;  // makes port 0 win the first tie
      rdata_r     <= '0;
    end else begin
      if (load_cmd_s) begin
        cmd_port_r  <= pick_winner_s;
        cmd_we_r    <= (pick_winner_s == P1) ? we1    : we0;
        cmd_addr_r  <= (pick_winner_s == P1) ? addr1  : addr0;
        cmd_wdata_r <= (pick_winner_s == P1) ? wdata1 : wdata0;
        last_gnt_r  <= pick_winner_s;
      end
      if (load_rdata_s) begin
        rdata_r <= ram_rdata;
      end
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign done0     = done0_r;
  assign done1     = done1_r;
  assign rdata     = rdata_r;
  assign busy      = (state_r != IDLE);
  // Address/data simply follow the latched command; only the strobe is qualified.
  assign ram_we    = (state_r == ISSUE) && cmd_we_r;
  assign ram_addr  = cmd_addr_r;
  assign ram_wdata = cmd_wdata_r;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter with a behavioural synchronous
// 4x4 RAM and a scoreboard of expected completions (port, read data).
module tb_ram_access_arbiter;

  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk, rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, busy, ram_we;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  ram_access_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write and synchronous read.
  logic [DW-1:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct { logic port; logic rd; logic [DW-1:0] data; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_mem [4];
  logic          exp_last;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Record an expected completion and advance the reference memory.
  task automatic push_exp(input logic port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    e.port = port;
    e.rd   = ~we;
    e.data = ref_mem[a];
    if (we) ref_mem[a] = d;
    sb.push_back(e);
  endtask

  // Completion monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (done0 || done1) begin
      exp_t e;
      chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_port", {31'd0, done1}, {31'd0, e.port});
        if (e.rd) chk("rdata", {28'd0, rdata}, {28'd0, e.data});
      end
    end
  end

  // Longest run of consecutive non-busy cycles while the sustained phase runs.
  logic sustain;
  int   low_run, max_low;
  always @(negedge clk) begin
    if (sustain) begin
      if (!busy) low_run++; else low_run = 0;
      if (low_run > max_low) max_low = low_run;
    end
  end

  // Single command from one port; starts and ends on a negedge.
  task automatic do_op(input logic port, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    push_exp(port, we, a, d);
    exp_last = port;
    @(negedge clk);  // cycle 1
    chk("op_gnt", {31'd0, port ? gnt1 : gnt0}, 32'd1);
    chk("op_ram_we", {31'd0, ram_we}, {31'd0, we});
    if (port) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);  // cycle 2
    if (we) begin
      chk("wr_done_c2", {31'd0, port ? done1 : done0}, 32'd1);
      chk("wr_busy_c2", {31'd0, busy}, 32'd0);
    end else begin
      chk("rd_nodone_c2", {31'd0, done0 | done1}, 32'd0);
      chk("rd_we_c2", {31'd0, ram_we}, 32'd0);
      @(negedge clk);  // cycle 3
      chk("rd_done_c3", {31'd0, port ? done1 : done0}, 32'd1);
    end
  endtask

  initial begin
    logic exp_port;
    int   cyc, prev_cyc, waited;
    logic got;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    sustain = 1'b0; low_run = 0; max_low = 0; exp_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_rdata", {28'd0, rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read from the other port.
    do_op(1'b0, 1'b1, 2'd0, 4'd10);
    do_op(1'b1, 1'b0, 2'd0, 4'd0);

    // Continuous contention: grants must alternate, 2 cycles apart.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 4'd5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd2; wdata1 = 4'd9;
    for (int k = 0; k < 4; k++) begin
      exp_port = ~exp_last;
      exp_last = exp_port;
      if (exp_port) push_exp(1'b1, 1'b1, 2'd2, 4'd9);
      else          push_exp(1'b0, 1'b1, 2'd1, 4'd5);
    end
    exp_last = 1'b1;
    cyc = 0; prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      got = 1'b0;
      while (!got && waited < 8) begin
        @(negedge clk);
        cyc++; waited++;
        got = gnt0 | gnt1;
      end
      chk("cont_gnt_seen", {31'd0, got}, 32'd1);
      exp_port = ~exp_last;
      exp_last = exp_port;
      chk("cont_port", {31'd0, gnt1}, {31'd0, exp_port});
      if (k > 0) chk("cont_gap", cyc - prev_cyc, 32'd2);
      prev_cyc = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);  // done cycle of last write
    do_op(1'b0, 1'b0, 2'd1, 4'd0);
    do_op(1'b1, 1'b0, 2'd2, 4'd0);

    // Top address is a distinct location.
    do_op(1'b0, 1'b1, 2'd3, 4'd15);
    do_op(1'b1, 1'b1, 2'd0, 4'd7);
    do_op(1'b0, 1'b0, 2'd3, 4'd0);
    do_op(1'b1, 1'b0, 2'd0, 4'd0);

    // Reset during RDWAIT aborts the read without a done pulse.
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    @(negedge clk);  // cycle 1 (ISSUE)
    req0 = 1'b0;
    @(negedge clk);  // cycle 2 (RDWAIT)
    chk("abort_busy_rdwait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", {30'd0, done1, done0}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
    chk("abort_rdata", {28'd0, rdata}, 32'd0);
    rst = 1'b0;
    exp_last = 1'b1;
    @(negedge clk);
    do_op(1'b0, 1'b0, 2'd3, 4'd0);

    // req1 raised only while port 0 is in ISSUE must be ignored.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 4'd3;
    push_exp(1'b0, 1'b1, 2'd2, 4'd3);
    exp_last = 1'b0;
    @(negedge clk);  // cycle 1 (ISSUE)
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 4'd0;
    @(negedge clk);  // cycle 2 (IDLE, done0)
    req1 = 1'b0;
    chk("ign_gnt1_c2", {31'd0, gnt1}, 32'd0);
    @(negedge clk);
    chk("ign_gnt1_c3", {31'd0, gnt1}, 32'd0);
    chk("ign_busy_c3", {31'd0, busy}, 32'd0);
    chk("ign_ram_we_c3", {31'd0, ram_we}, 32'd0);
    do_op(1'b1, 1'b0, 2'd3, 4'd0);  // still 15
    do_op(1'b1, 1'b0, 2'd2, 4'd0);  // 3

    // Sustained port-0 traffic, alternating writes and reads.
    sustain = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) do_op(1'b0, 1'b1, 2'(k % 4), 4'(k + 1));
      else            do_op(1'b0, 1'b0, 2'((k - 1) % 4), 4'd0);
    end
    sustain = 1'b0;
    chk("sustain_max_idle", max_low, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
